// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller for the 16-bit datapath ALU
// Decodes compact requests into one-hot ALU opcodes and returns masked, captured results.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_func,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_data_i,
  output logic [DATA_W-1:0] alu_data_j,
  output logic [6:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_eq,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_eq,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  ops_done,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [6:0] OP_CMP = 7'b1000111;

  function automatic logic [6:0] decode(input logic [2:0] f);
    case (f)
      3'd0:    decode = 7'b0000001;
      3'd1:    decode = 7'b0000010;
      3'd2:    decode = 7'b0000100;
      3'd3:    decode = 7'b0001000;
      3'd4:    decode = 7'b0010000;
      3'd5:    decode = 7'b0100000;
      3'd6:    decode = OP_CMP;
      default: decode = 7'b0000000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic [6:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] data_i_q, data_i_d;
  logic [DATA_W-1:0] data_j_q, data_j_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_eq_q, rsp_eq_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    alu_op_d     = alu_op_q;
    data_i_d     = data_i_q;
    data_j_d     = data_j_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_eq_d     = rsp_eq_q;
    rsp_err_d    = rsp_err_q;
    ops_done_d   = ops_done_q;
    err_cnt_d    = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_i_d    = req_a;
          data_j_d    = req_b;
          alu_op_d    = decode(req_func);
          req_ready_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        // The ALU leaves result undriven on CMP and eq undriven otherwise, so mask both.
        rsp_result_d = '0;
        rsp_eq_d     = 1'b0;
        rsp_err_d    = 1'b0;
        if (alu_op_q == OP_CMP)
          rsp_eq_d = alu_eq;
        else if (alu_op_q == 7'b0000000)
          rsp_err_d = 1'b1;
        else
          rsp_result_d = alu_result;
        alu_op_d    = 7'b0000000;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          ops_done_d  = ops_done_q + CNT_W'(1);
          err_cnt_d   = err_cnt_q + CNT_W'(rsp_err_q);
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        alu_op_d    = 7'b0000000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      alu_op_q     <= '0;
      data_i_q     <= '0;
      data_j_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_eq_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      alu_op_q     <= alu_op_d;
      data_i_q     <= data_i_d;
      data_j_q     <= data_j_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_eq_q     <= rsp_eq_d;
      rsp_err_q    <= rsp_err_d;
      ops_done_q   <= ops_done_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign alu_op     = alu_op_q;
  assign alu_data_i = data_i_q;
  assign alu_data_j = data_j_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_eq     = rsp_eq_q;
  assign rsp_err    = rsp_err_q;
  assign ops_done   = ops_done_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
// Behavioural ALU drives junk on the outputs the controller must mask.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_data_i, alu_data_j;
  logic [6:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_eq;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_eq;
  logic        rsp_err;
  logic [7:0]  ops_done;
  logic [7:0]  err_cnt;

  alu_issue_ctrl #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_a(req_a), .req_b(req_b),
    .alu_data_i(alu_data_i), .alu_data_j(alu_data_j), .alu_op(alu_op),
    .alu_result(alu_result), .alu_eq(alu_eq),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_eq(rsp_eq), .rsp_err(rsp_err),
    .ops_done(ops_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_result = 16'h5A5A;
    alu_eq     = 1'b1;
    case (alu_op)
      7'b0000001: alu_result = alu_data_j;
      7'b0000010: alu_result = alu_data_i + alu_data_j;
      7'b0000100: alu_result = alu_data_i - alu_data_j;
      7'b0001000: alu_result = alu_data_i & alu_data_j;
      7'b0010000: alu_result = alu_data_i | alu_data_j;
      7'b0100000: alu_result = ~alu_data_j;
      7'b1000111: begin
        alu_result = 16'hA5A5;
        alu_eq     = (alu_data_i == alu_data_j);
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [15:0] result;
    logic        eq;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [2:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [6:0]  exp_op;
    rsp_t        exp_rsp;
    int          stall;
  } vec_t;

  rsp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_ops = 8'd0;
  logic [7:0] exp_errs = 8'd0;
  int         accept_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic [6:0] exp_op, input rsp_t exp_rsp, input int stall);
    int          guard;
    logic [15:0] held;
    rsp_t        want;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b;
    @(posedge clk); #1;
    accept_cyc = cyc;
    sb.push_back(exp_rsp);
    req_func = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    check("exec_alu_op", {25'd0, alu_op}, {25'd0, exp_op});
    check("exec_req_ready", {31'd0, req_ready}, 32'd0);
    check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("exec_data_i", {16'd0, alu_data_i}, {16'd0, a});
    check("exec_data_j", {16'd0, alu_data_j}, {16'd0, b});
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("latency_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp_alu_op", {25'd0, alu_op}, 32'd0);
    check("resp_data_i_held", {16'd0, alu_data_i}, {16'd0, a});
    held = rsp_result;
    for (int s = 0; s < stall; s++) begin
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_result_stable", {16'd0, rsp_result}, {16'd0, held});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    want = sb.pop_front();
    check("rsp_result", {16'd0, rsp_result}, {16'd0, want.result});
    check("rsp_eq", {31'd0, rsp_eq}, {31'd0, want.eq});
    check("rsp_err", {31'd0, rsp_err}, {31'd0, want.err});
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_ops  = exp_ops + 8'd1;
    exp_errs = exp_errs + {7'd0, want.err};
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    check("ops_done", {24'd0, ops_done}, {24'd0, exp_ops});
    check("err_cnt", {24'd0, err_cnt}, {24'd0, exp_errs});
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ops = 8'd0; exp_errs = 8'd0;
    sb.delete();
  endtask

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_cyc;
    vecs[0] = '{3'd1, 16'h7FFF, 16'h0001, 7'b0000010, '{16'h8000, 1'b0, 1'b0}, 0};
    vecs[1] = '{3'd2, 16'h0000, 16'h0001, 7'b0000100, '{16'hFFFF, 1'b0, 1'b0}, 5};
    vecs[2] = '{3'd6, 16'h1234, 16'h1234, 7'b1000111, '{16'h0000, 1'b1, 1'b0}, 0};
    vecs[3] = '{3'd6, 16'h1234, 16'h1235, 7'b1000111, '{16'h0000, 1'b0, 1'b0}, 1};
    vecs[4] = '{3'd7, 16'h0F0F, 16'h1111, 7'b0000000, '{16'h0000, 1'b0, 1'b1}, 2};
    vecs[5] = '{3'd0, 16'h1111, 16'hBEEF, 7'b0000001, '{16'hBEEF, 1'b0, 1'b0}, 0};
    vecs[6] = '{3'd5, 16'h1357, 16'h0000, 7'b0100000, '{16'hFFFF, 1'b0, 1'b0}, 0};
    vecs[7] = '{3'd3, 16'hF0F0, 16'h3C3C, 7'b0001000, '{16'h3030, 1'b0, 1'b0}, 3};
    vecs[8] = '{3'd4, 16'hF0F0, 16'h0F01, 7'b0010000, '{16'hFFF1, 1'b0, 1'b0}, 0};
    vecs[9] = '{3'd1, 16'hFFFF, 16'h0002, 7'b0000010, '{16'h0001, 1'b0, 1'b0}, 0};

    req_func = 3'd0; req_a = 16'd0; req_b = 16'd0;
    do_reset();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_op", {25'd0, alu_op}, 32'd0);
    check("rst_data_i", {16'd0, alu_data_i}, 32'd0);
    check("rst_rsp_result", {16'd0, rsp_result}, 32'd0);
    check("rst_ops_done", {24'd0, ops_done}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Reset while an ADD is in EXEC: the op must vanish without a response or count.
    req_valid = 1'b1; req_func = 3'd1; req_a = 16'd5; req_b = 16'd6;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midop_exec_alu_op", {25'd0, alu_op}, 32'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midop_req_ready", {31'd0, req_ready}, 32'd1);
    check("midop_alu_op", {25'd0, alu_op}, 32'd0);
    check("midop_ops_done", {24'd0, ops_done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midop_no_rsp", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].exp_op, vecs[i].exp_rsp, vecs[i].stall);

    do_reset();
    prev_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      rsp_t        r;
      a = 16'(i * 16'h0101);
      r.result = a + 16'h00FF;
      r.eq = 1'b0;
      r.err = 1'b0;
      do_op(3'd1, a, 16'h00FF, 7'b0000010, r, 0);
      if (i > 0) check("throughput", 32'(accept_cyc - prev_cyc), 32'd3);
      prev_cyc = accept_cyc;
    end
    check("ops_done_wrap", {24'd0, ops_done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
